// File: rtl/stream_pkg.sv
// Shared types and constants for the stream demultiplexer slice.
package stream_pkg;

  // Packet-framing FSM: IDLE = no packet open, PKT = route locked for open packet.
  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } demux_state_t;

  // Route encoding: which output a packet is steered to.
  localparam logic ROUTE_M0 = 1'b0;
  localparam logic ROUTE_M1 = 1'b1;

  // A packet is open (route locked) only in PKT.
  function automatic logic packet_open(input demux_state_t st);
    return (st == PKT);
  endfunction

endpackage

// File: rtl/stream_demux_2_if.sv
// Valid/ready byte stream with packet framing (last flag).
interface stream_demux_2_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             last;

  // Producer side of a stream.
  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  // Consumer side of a stream.
  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );
endinterface

// File: rtl/stream_out_reg.sv
// One-entry output register with valid/ready. A load always wins over a
// drain in the same cycle, so a full-rate stream passes with no bubble.
module stream_out_reg #(
  parameter int PAYLOAD_W = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [PAYLOAD_W-1:0] load_payload,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 free
);

  logic                 valid_reg;
  logic [PAYLOAD_W-1:0] payload_reg;

  // Register can take a new beat when empty or when its beat leaves this cycle.
  assign free        = !valid_reg || out_ready;
  assign out_valid   = valid_reg;
  assign out_payload = payload_reg;

  // Valid flag: set on load, cleared on handshake with no concurrent load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  // Payload captured only on load so it stays stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      payload_reg <= '0;
    end else if (load) begin
      payload_reg <= load_payload;
    end
  end

endmodule

// File: rtl/stream_demux_2.sv
// Two-output packet demultiplexer: each packet is steered whole to m0 or m1
// by sel sampled on its first beat. Each output owns a one-entry register,
// so a stalled sink only blocks traffic routed to it.
module stream_demux_2
  import stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_demux_2_if.slave  s,
  stream_demux_2_if.master m0,
  stream_demux_2_if.master m1,
  input  logic             sel,
  output logic             busy,
  output logic             route
);

  localparam int PAYLOAD_W = WIDTH + 1;

  demux_state_t state_reg, state_next;
  logic         route_reg, route_next;
  logic         eff_route;
  logic         accept;

  logic                 free_w    [2];
  logic                 load_w    [2];
  logic                 ready_w   [2];
  logic                 valid_w   [2];
  logic [PAYLOAD_W-1:0] payload_w [2];

  // In IDLE the new packet follows sel; inside a packet the locked route holds.
  assign eff_route = packet_open(state_reg) ? route_reg : sel;

  // Input is ready exactly when the addressed output register can take a beat.
  assign s.ready = free_w[eff_route];
  assign accept  = s.valid && s.ready;

  assign busy  = packet_open(state_reg);
  assign route = route_reg;

  assign ready_w[0] = m0.ready;
  assign ready_w[1] = m1.ready;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_out
      localparam logic MY_ROUTE = (gi == 0) ? ROUTE_M0 : ROUTE_M1;

      assign load_w[gi] = accept && (eff_route == MY_ROUTE);

      stream_out_reg #(
        .PAYLOAD_W(PAYLOAD_W)
      ) u_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load_w[gi]),
        .load_payload({s.data, s.last}),
        .out_ready   (ready_w[gi]),
        .out_valid   (valid_w[gi]),
        .out_payload (payload_w[gi]),
        .free        (free_w[gi])
      );
    end
  endgenerate

  assign m0.valid = valid_w[0];
  assign m0.data  = payload_w[0][PAYLOAD_W-1:1];
  assign m0.last  = payload_w[0][0];
  assign m1.valid = valid_w[1];
  assign m1.data  = payload_w[1][PAYLOAD_W-1:1];
  assign m1.last  = payload_w[1][0];

  // FSM state and locked route register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      route_reg <= ROUTE_M0;
    end else begin
      state_reg <= state_next;
      route_reg <= route_next;
    end
  end

  // Next-state: open a packet on a non-last first beat, close on a last beat.
  // A single-beat packet leaves the FSM in IDLE with nothing latched.
  always_comb begin
    state_next = state_reg;
    route_next = route_reg;
    if (accept) begin
      case (state_reg)
        IDLE: begin
          if (!s.last) begin
            state_next = PKT;
            route_next = sel;
          end
        end
        PKT: begin
          if (s.last) begin
            state_next = IDLE;
            route_next = ROUTE_M0;
          end
        end
        default: begin
          state_next = IDLE;
          route_next = ROUTE_M0;
        end
      endcase
    end
  end

endmodule
